// File: rtl/gem_ext_fifo_tx_pktbuf.sv
// Store-and-forward byte packet buffer feeding the GEM external-FIFO transmit stage.
// Frames become readable only once committed; errored, oversize or overflowing frames roll back and are counted.
module gem_ext_fifo_tx_pktbuf #(
   parameter int DEPTH_LOG2 = 11,
   parameter int PKT_CNT_W  = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic [PKT_CNT_W-1:0] pkt_count,
   output logic [15:0]          drop_count,
   output logic                 drop_pulse
);

   localparam int PW = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [PW-1:0] FULL_USED = PW'(DEPTH);
   localparam logic [PKT_CNT_W-1:0] PKT_MAX = '1;

   logic [8:0]            mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         wr_commit;
   logic [PW-1:0]         rd_ptr;
   logic                  drop_flag;
   logic                  out_valid;
   logic                  out_last;
   logic [7:0]            out_data;

   logic                  full;
   logic                  in_beat;
   logic                  in_write;
   logic                  in_last;
   logic                  frame_drop;
   logic                  commit;
   logic                  out_hs;
   logic                  out_last_hs;
   logic                  load_first;
   logic                  load_next;
   logic [DEPTH_LOG2-1:0] rd_addr;

   // Both ports: a beat transfers on a rising edge where valid and ready are both high;
   // the output beat holds unchanged while valid is high and ready is low.
   assign s_axis_tready = ~rst;
   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = out_data;
   assign m_axis_tlast  = out_last;

   assign full       = (wr_ptr - rd_ptr) == FULL_USED;
   assign in_beat    = s_axis_tvalid & s_axis_tready;
   assign in_write   = in_beat & ~full & ~drop_flag;
   assign in_last    = in_beat & s_axis_tlast;
   assign frame_drop = in_last & (drop_flag | full | s_axis_tuser | (pkt_count == PKT_MAX));
   assign commit     = in_last & ~frame_drop;

   // rd_ptr addresses the byte sitting in the output register, so that byte still counts as used.
   assign out_hs      = out_valid & m_axis_tready;
   assign out_last_hs = out_hs & out_last;
   assign load_first  = ~out_valid & (pkt_count != '0);
   assign load_next   = out_hs & ~out_last;
   assign rd_addr     = load_next ? rd_ptr[DEPTH_LOG2-1:0] + 1'b1 : rd_ptr[DEPTH_LOG2-1:0];

   always_ff @(posedge clk) begin
      if (in_write) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_last <= 1'b0;
      end else if (load_first || load_next) begin
         {out_last, out_data} <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         wr_commit  <= '0;
         rd_ptr     <= '0;
         drop_flag  <= 1'b0;
         pkt_count  <= '0;
         drop_count <= '0;
         drop_pulse <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         drop_pulse <= frame_drop;
         if (frame_drop) begin
            wr_ptr    <= wr_commit;
            drop_flag <= 1'b0;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end else begin
            if (in_write) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
               wr_commit <= wr_ptr + 1'b1;
               drop_flag <= 1'b0;
            end else if (in_beat && !in_write) begin
               drop_flag <= 1'b1;
            end
         end

         if (out_hs) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Clearing valid after a tlast handshake gives the one-cycle prefetch bubble.
         if (load_first) begin
            out_valid <= 1'b1;
         end else if (out_last_hs) begin
            out_valid <= 1'b0;
         end

         case ({commit, out_last_hs})
            2'b10:   pkt_count <= pkt_count + 1'b1;
            2'b01:   pkt_count <= pkt_count - 1'b1;
            default: pkt_count <= pkt_count;
         endcase
      end
   end

endmodule

// File: tb/tb_gem_ext_fifo_tx_pktbuf.sv
// Bench for gem_ext_fifo_tx_pktbuf: frame-level reference model feeding an expected-beat queue,
// a default-size instance for the main scenarios and a 16-byte instance for overflow and frame-count limits.
module tb_gem_ext_fifo_tx_pktbuf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        s_tuser = 1'b0;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        m_tlast;
   logic [5:0]  pkt_count;
   logic [15:0] drop_count;
   logic        drop_pulse;

   logic [7:0]  sm_s_tdata = '0;
   logic        sm_s_tvalid = 1'b0;
   logic        sm_s_tlast = 1'b0;
   logic        sm_s_tuser = 1'b0;
   logic        sm_s_tready;
   logic [7:0]  sm_m_tdata;
   logic        sm_m_tvalid;
   logic        sm_m_tready = 1'b0;
   logic        sm_m_tlast;
   logic [1:0]  sm_pkt_count;
   logic [15:0] sm_drop_count;
   logic        sm_drop_pulse;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [8:0]  exp_q[$];
   int          exp_drops = 0;
   int          rdy_mode = 3;   // 0 manual, 1 always ready, 2 toggle, 3 hold low, 4 random
   bit          mon_en = 1'b0;
   bit          strict_rise = 1'b0;

   gem_ext_fifo_tx_pktbuf u_dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .pkt_count     (pkt_count),
      .drop_count    (drop_count),
      .drop_pulse    (drop_pulse)
   );

   gem_ext_fifo_tx_pktbuf #(.DEPTH_LOG2(4), .PKT_CNT_W(2)) u_small (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (sm_s_tdata),
      .s_axis_tvalid (sm_s_tvalid),
      .s_axis_tready (sm_s_tready),
      .s_axis_tlast  (sm_s_tlast),
      .s_axis_tuser  (sm_s_tuser),
      .m_axis_tdata  (sm_m_tdata),
      .m_axis_tvalid (sm_m_tvalid),
      .m_axis_tready (sm_m_tready),
      .m_axis_tlast  (sm_m_tlast),
      .pkt_count     (sm_pkt_count),
      .drop_count    (sm_drop_count),
      .drop_pulse    (sm_drop_pulse)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic drive_beat(input logic [7:0] d, input logic l, input logic u);
      s_tdata  = d;
      s_tlast  = l;
      s_tuser  = u;
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic sm_drive_beat(input logic [7:0] d, input logic l);
      sm_s_tdata  = d;
      sm_s_tlast  = l;
      sm_s_tuser  = 1'b0;
      sm_s_tvalid = 1'b1;
      @(posedge clk);
      #1;
      sm_s_tvalid = 1'b0;
      sm_s_tlast  = 1'b0;
   endtask

   // Frame-level model: a frame reaches the output whole and in order unless its tlast carries tuser.
   task automatic send_frame(input int len, input bit user, input bit seq, input bit gaps);
      logic [8:0] frm[$];
      logic [7:0] d;
      logic       u;
      for (int i = 0; i < len; i++) begin
         d = seq ? 8'(i) : 8'($urandom_range(0, 255));
         frm.push_back({1'(i == len - 1), d});
         u = (i == len - 1) ? user : 1'($urandom_range(0, 1));
         if (i == len - 1) begin
            if (user) exp_drops++;
            else foreach (frm[k]) exp_q.push_back(frm[k]);
         end
         drive_beat(d, 1'(i == len - 1), u);
         if (gaps && i != len - 1 && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic ready_driver();
      bit tog = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: m_tready = 1'b1;
            2: begin tog = ~tog; m_tready = tog; end
            3: m_tready = 1'b0;
            4: m_tready = 1'($urandom_range(0, 1));
            default: ;
         endcase
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic monitor();
      logic [8:0] got;
      logic [8:0] want;
      logic [8:0] held = '0;
      bit stall_d = 1'b0, hs_mid_d = 1'b0, hs_last_d1 = 1'b0, hs_last_d2 = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            stall_d = 1'b0; hs_mid_d = 1'b0; hs_last_d1 = 1'b0; hs_last_d2 = 1'b0;
         end else begin
            got = {m_tlast, m_tdata};
            if (stall_d) begin
               n_checks++;
               if (m_tvalid !== 1'b1 || got !== held)
                  $display("FAIL hold: valid=%b beat=%h required valid=1 beat=%h", m_tvalid, got, held);
               else n_pass++;
            end
            if (hs_mid_d) begin
               n_checks++;
               if (m_tvalid !== 1'b1) $display("FAIL no_gap: valid=%b required 1 inside frame", m_tvalid);
               else n_pass++;
            end
            if (hs_last_d1) begin
               n_checks++;
               if (m_tvalid !== 1'b0) $display("FAIL bubble: valid=%b required 0 after tlast", m_tvalid);
               else n_pass++;
            end
            if (hs_last_d2 && strict_rise && exp_q.size() != 0) begin
               n_checks++;
               if (m_tvalid !== 1'b1) $display("FAIL rise: valid=%b required 1 after bubble", m_tvalid);
               else n_pass++;
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  $display("FAIL beat: got unexpected beat %h required none", got);
               end else begin
                  want = exp_q.pop_front();
                  if (got !== want) $display("FAIL beat: got %h required %h", got, want);
                  else n_pass++;
               end
            end
            hs_last_d2 = hs_last_d1;
            stall_d    = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            held       = got;
            hs_mid_d   = (m_tvalid === 1'b1) && (m_tready === 1'b1) && (m_tlast === 1'b0);
            hs_last_d1 = (m_tvalid === 1'b1) && (m_tready === 1'b1) && (m_tlast === 1'b1);
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: %0d beats outstanding after %0d cycles, required 0", exp_q.size(), n);
         exp_q.delete();
      end else n_pass++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({s_tready, m_tvalid, m_tlast, m_tdata, pkt_count, drop_count, drop_pulse} !== '0)
         $display("FAIL reset_main: outputs=%h required 0",
                  {s_tready, m_tvalid, m_tlast, m_tdata, pkt_count, drop_count, drop_pulse});
      else n_pass++;
      n_checks++;
      if ({sm_s_tready, sm_m_tvalid, sm_m_tlast, sm_m_tdata, sm_pkt_count, sm_drop_count, sm_drop_pulse} !== '0)
         $display("FAIL reset_small: outputs=%h required 0",
                  {sm_s_tready, sm_m_tvalid, sm_m_tlast, sm_m_tdata, sm_pkt_count, sm_drop_count, sm_drop_pulse});
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (s_tready !== 1'b1 || sm_s_tready !== 1'b1)
         $display("FAIL ready_after_reset: tready=%b/%b required 1/1", s_tready, sm_s_tready);
      else n_pass++;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_frame();
      rdy_mode = 1;
      repeat (2) begin @(posedge clk); #1; end
      n_checks++;
      if (pkt_count !== 6'd0) $display("FAIL single_idle: pkt_count=%0d required 0", pkt_count);
      else n_pass++;
      send_frame(64, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (m_tvalid !== 1'b0 || pkt_count !== 6'd1)
         $display("FAIL single_t1: valid=%b pkt_count=%0d required 0/1", m_tvalid, pkt_count);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h00)
         $display("FAIL single_t2: valid=%b data=%h required 1/00", m_tvalid, m_tdata);
      else n_pass++;
      @(posedge clk);
      #1;
      wait_drain(300);
      n_checks++;
      if (pkt_count !== 6'd0) $display("FAIL single_done: pkt_count=%0d required 0", pkt_count);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      rdy_mode = 3;
      repeat (2) begin @(posedge clk); #1; end
      strict_rise = 1'b1;
      send_frame(10, 1'b0, 1'b0, 1'b0);
      send_frame(1, 1'b0, 1'b0, 1'b0);
      send_frame(300, 1'b0, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (pkt_count !== 6'd3) $display("FAIL b2b_peak: pkt_count=%0d required 3", pkt_count);
      else n_pass++;
      rdy_mode = 2;
      wait_drain(2000);
      strict_rise = 1'b0;
      n_checks++;
      if (pkt_count !== 6'd0) $display("FAIL b2b_done: pkt_count=%0d required 0", pkt_count);
      else n_pass++;
   endtask

   task automatic test_tuser_drop();
      rdy_mode = 1;
      send_frame(20, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (drop_pulse !== 1'b1 || pkt_count !== 6'd0)
         $display("FAIL tuser_pulse: drop_pulse=%b pkt_count=%0d required 1/0", drop_pulse, pkt_count);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (drop_pulse !== 1'b0 || drop_count !== 16'(exp_drops))
         $display("FAIL tuser_once: drop_pulse=%b drop_count=%0d required 0/%0d", drop_pulse, drop_count, exp_drops);
      else n_pass++;
      @(posedge clk);
      #1;
      send_frame(8, 1'b0, 1'b0, 1'b0);
      wait_drain(100);
      n_checks++;
      if (pkt_count !== 6'd0 || drop_count !== 16'(exp_drops))
         $display("FAIL tuser_after: pkt_count=%0d drop_count=%0d required 0/%0d", pkt_count, drop_count, exp_drops);
      else n_pass++;
   endtask

   task automatic test_commit_collision();
      logic [8:0] frm[$];
      logic [7:0] d;
      rdy_mode = 0;
      m_tready = 1'b0;
      send_frame(4, 1'b0, 1'b1, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      // Output takes frame A's tlast on the same edge frame B's tlast is accepted.
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         frm.push_back({1'(i == 5), d});
         if (i == 5) foreach (frm[k]) exp_q.push_back(frm[k]);
         m_tready = (i >= 2);
         drive_beat(d, 1'(i == 5), 1'b0);
      end
      m_tready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pkt_count !== 6'd1 || m_tvalid !== 1'b0)
         $display("FAIL collision_count: pkt_count=%0d valid=%b required 1/0", pkt_count, m_tvalid);
      else n_pass++;
      n_checks++;
      if (exp_q.size() != 6) $display("FAIL collision_first_done: outstanding=%0d required 6", exp_q.size());
      else n_pass++;
      @(posedge clk);
      #1;
      rdy_mode = 1;
      wait_drain(100);
      n_checks++;
      if (pkt_count !== 6'd0) $display("FAIL collision_done: pkt_count=%0d required 0", pkt_count);
      else n_pass++;
   endtask

   task automatic test_random();
      rdy_mode = 4;
      for (int f = 0; f < 12; f++) begin
         send_frame($urandom_range(1, 80), 1'($urandom_range(0, 4) == 0), 1'b0, 1'b1);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      wait_drain(4000);
      n_checks++;
      if (pkt_count !== 6'd0 || drop_count !== 16'(exp_drops))
         $display("FAIL random_done: pkt_count=%0d drop_count=%0d required 0/%0d", pkt_count, drop_count, exp_drops);
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [8:0] sm_exp[$];
      logic [8:0] want;
      sm_m_tready = 1'b0;
      for (int i = 0; i < 17; i++) sm_drive_beat(8'(8'h80 + i), 1'(i == 16));
      @(negedge clk);
      n_checks++;
      if (sm_drop_pulse !== 1'b1 || sm_drop_count !== 16'd1 || sm_pkt_count !== 2'd0)
         $display("FAIL ovf_oversize: pulse=%b drops=%0d pkts=%0d required 1/1/0", sm_drop_pulse, sm_drop_count, sm_pkt_count);
      else n_pass++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         sm_exp.push_back({1'(i == 15), 8'(8'h40 + i)});
         sm_drive_beat(8'(8'h40 + i), 1'(i == 15));
      end
      @(negedge clk);
      n_checks++;
      if (sm_pkt_count !== 2'd1 || sm_drop_count !== 16'd1)
         $display("FAIL ovf_exact_fit: pkts=%0d drops=%0d required 1/1", sm_pkt_count, sm_drop_count);
      else n_pass++;
      @(posedge clk);
      #1;
      sm_drive_beat(8'hEE, 1'b1);
      @(negedge clk);
      n_checks++;
      if (sm_pkt_count !== 2'd1 || sm_drop_count !== 16'd2)
         $display("FAIL ovf_full_boundary: pkts=%0d drops=%0d required 1/2", sm_pkt_count, sm_drop_count);
      else n_pass++;
      @(posedge clk);
      #1;
      sm_m_tready = 1'b1;
      for (int c = 0; c < 200 && sm_exp.size() != 0; c++) begin
         @(negedge clk);
         if (sm_m_tvalid === 1'b1) begin
            n_checks++;
            want = sm_exp.pop_front();
            if ({sm_m_tlast, sm_m_tdata} !== want)
               $display("FAIL ovf_beat: got %h required %h", {sm_m_tlast, sm_m_tdata}, want);
            else n_pass++;
         end
      end
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (sm_exp.size() != 0 || sm_m_tvalid !== 1'b0 || sm_pkt_count !== 2'd0)
         $display("FAIL ovf_drained: outstanding=%0d valid=%b pkts=%0d required 0/0/0", sm_exp.size(), sm_m_tvalid, sm_pkt_count);
      else n_pass++;

      sm_m_tready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k < 3) sm_exp.push_back({1'b1, 8'(8'hA0 + k)});
         sm_drive_beat(8'(8'hA0 + k), 1'b1);
      end
      @(negedge clk);
      n_checks++;
      if (sm_pkt_count !== 2'd3 || sm_drop_count !== 16'd3)
         $display("FAIL pkt_limit: pkts=%0d drops=%0d required 3/3", sm_pkt_count, sm_drop_count);
      else n_pass++;
      @(posedge clk);
      #1;
      sm_m_tready = 1'b1;
      for (int c = 0; c < 100 && sm_exp.size() != 0; c++) begin
         @(negedge clk);
         if (sm_m_tvalid === 1'b1) begin
            n_checks++;
            want = sm_exp.pop_front();
            if ({sm_m_tlast, sm_m_tdata} !== want)
               $display("FAIL limit_beat: got %h required %h", {sm_m_tlast, sm_m_tdata}, want);
            else n_pass++;
         end
      end
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (sm_exp.size() != 0 || sm_pkt_count !== 2'd0)
         $display("FAIL limit_drained: outstanding=%0d pkts=%0d required 0/0", sm_exp.size(), sm_pkt_count);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      rdy_mode = 1;
      send_frame(30, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive_beat(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      mon_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_tready !== 1'b0) $display("FAIL mid_rst_tready: tready=%b required 0", s_tready);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_drops = 0;
      @(negedge clk);
      n_checks++;
      if ({m_tvalid, m_tlast, m_tdata, pkt_count, drop_count, drop_pulse} !== '0 || s_tready !== 1'b1)
         $display("FAIL mid_rst_clear: outputs=%h tready=%b required 0/1",
                  {m_tvalid, m_tlast, m_tdata, pkt_count, drop_count, drop_pulse}, s_tready);
      else n_pass++;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      send_frame(12, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (m_tvalid !== 1'b0 || pkt_count !== 6'd1)
         $display("FAIL mid_rst_t1: valid=%b pkt_count=%0d required 0/1", m_tvalid, pkt_count);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h00)
         $display("FAIL mid_rst_t2: valid=%b data=%h required 1/00", m_tvalid, m_tdata);
      else n_pass++;
      @(posedge clk);
      #1;
      wait_drain(100);
      n_checks++;
      if (pkt_count !== 6'd0 || drop_count !== 16'd0)
         $display("FAIL mid_rst_done: pkt_count=%0d drop_count=%0d required 0/0", pkt_count, drop_count);
      else n_pass++;
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      fork
         monitor();
         ready_driver();
      join_none
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_tuser_drop();
      test_commit_collision();
      test_random();
      test_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
